// File: rtl/regfile_wb_arbiter.sv
// Three-way round-robin arbiter feeding one register-file write port through a 1-cycle output stage.
// Grant is combinational; an address-0 write is consumed but never enables the register file.
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [2:0]        req_valid,
    output logic [2:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [1:0]        rf_gid
);

    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        win;
    logic              any_vld;
    logic [2:0]        idx;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        gid_q;

    // Scan ptr, ptr+1, ptr+2 (mod 3); first valid requester wins.
    always_comb begin
        win     = ptr_q;
        any_vld = 1'b0;
        idx     = 3'd0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, ptr_q} + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (!any_vld && req_valid[idx[1:0]]) begin
                any_vld = 1'b1;
                win     = idx[1:0];
            end
        end
    end

    assign xfer      = any_vld && !hold && !rst;
    assign req_ready = xfer ? (3'b001 << win) : 3'b000;

    always_comb begin
        sel_addr = req_addr0;
        sel_data = req_data0;
        case (win)
            2'd1: begin
                sel_addr = req_addr1;
                sel_data = req_data1;
            end
            2'd2: begin
                sel_addr = req_addr2;
                sel_data = req_data2;
            end
            default: begin
                sel_addr = req_addr0;
                sel_data = req_data0;
            end
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
        end
    end

    // Address/data/gid hold their last value when nothing transfers; only the enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= 2'd0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            gid_q   <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
            we_q  <= xfer && (sel_addr != '0);
            if (xfer) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
                gid_q   <= win;
            end
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign rf_gid   = gid_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port hold  input  1  freezes arbitration while 1.
REQ-006 The block SHALL have port req_valid  input  3  per-requester write request; bit i is requester i.
REQ-007 The block SHALL have port req_ready  output  3  per-requester grant; a transfer occurs on a cycle where valid[i] and ready[i] are both 1.
REQ-008 The block SHALL have ports req_addr0/1/2  input  ADDR_W  destination register, one per requester.
REQ-009 The block SHALL have ports req_data0/1/2  input  DATA_W  write data, one per requester.
REQ-010 The block SHALL have port rf_we  output  1  register-file write enable.
REQ-011 The block SHALL have port rf_waddr  output  ADDR_W  register-file write address.
REQ-012 The block SHALL have port rf_wdata  output  DATA_W  register-file write data.
REQ-013 The block SHALL have port rf_gid  output  2  index of the requester whose write is on rf_* this cycle.

Function
REQ-014 The block SHALL hold a 2-bit round-robin pointer ptr in {0,1,2}; value 3 is unreachable.
REQ-015 Each cycle with rst=0 and hold=0, the winner SHALL be the first i with req_valid[i]=1 in the order ptr, ptr+1, ptr+2 (mod 3).
REQ-016 req_ready SHALL be combinational, one-hot on the winner, and all-zero when hold=1, rst=1 or no requester is valid.
REQ-017 req_ready[i] SHALL never be 1 while req_valid[i]=0.
REQ-018 On a transfer, ptr SHALL become (winner+1) mod 3 at the next edge; with no transfer, ptr SHALL be unchanged.
REQ-019 A transfer SHALL be registered into the output stage with 1-cycle latency: next cycle rf_waddr=addr, rf_wdata=data, rf_gid=winner.
REQ-020 rf_we SHALL be 1 in the cycle after a transfer with addr != 0.
REQ-021 A transfer with addr = 0 SHALL be accepted (ready=1) and consumed, but rf_we SHALL be 0 in the following cycle.
REQ-022 In a cycle after no transfer, rf_we SHALL be 0; rf_waddr, rf_wdata and rf_gid SHALL hold their previous values.
REQ-023 At most one write SHALL reach the register file per cycle; unserved requesters SHALL keep valid, addr and data stable until granted.
REQ-024 Each continuously-valid requester SHALL be granted within 3 cycles of hold=0 cycles (fairness bound).
REQ-025 A requester dropping valid before it is granted SHALL be legal; nothing is recorded for it.
REQ-026 hold=1 SHALL not change ptr and SHALL force rf_we=0 on the next cycle; an output already registered SHALL still appear on the cycle when hold rises.

Reset
REQ-027 While rst=1, the block SHALL drive ptr=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_gid=0 and req_ready=0.
REQ-028 Asserting rst mid-operation SHALL discard the registered write immediately (rf_we=0 asynchronously); no pending transfer SHALL survive reset.
REQ-029 The first cycle after rst falls SHALL arbitrate with ptr=0.

Verification
REQ-030 Reset, then valid=3'b111 with addr0/1/2=1/2/3, data=A/B/C, held: grants 0,1,2,0 on consecutive cycles; rf_waddr 1,2,3,1 each one cycle later with rf_we=1.
REQ-031 Only valid[1]=1, addr=5, data=32'hDEADBEEF for 1 cycle: ready=3'b010 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF, rf_gid=1; the cycle after that rf_we=0.
REQ-032 valid[2]=1 with addr=0, data=32'h1234: ready[2]=1; next cycle rf_we=0; ptr becomes 0.
REQ-033 valid=3'b111 with hold=1 for 4 cycles: req_ready=0 and rf_we=0 throughout; after hold falls, the first grant goes to the requester at the unchanged ptr.
REQ-034 Transfer in cycle N, rst pulsed mid-cycle N+1: rf_we drops to 0 immediately; after release, req_ready=3'b001 for valid=3'b111.
